crc16_frame_tx: RTL



---
 rtl/crc16_frame_tx_if.sv | 46 ++++
 rtl/crc16_frame_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : crc16_frame_tx_if
//  Brief    : Payload-source / frame-transmitter bundle for crc16_frame_tx.
//             The master side (payload source) raises start with a payload.
//             The slave side (transmitter) returns the serial line, the
//             status flags and the CRC of the last completed frame.
//  Revision : 1.0  initial release
// ============================================================================
interface crc16_frame_tx_if #(
    parameter int PAYLOAD_BITS = 24
);
    // Request side: driven by the payload source.
    logic                    start;
    logic [PAYLOAD_BITS-1:0] data_in;

    // Serial line and status: driven by the transmitter.
    logic                    tx_bit;
    logic                    tx_valid;
    logic                    busy;
    logic                    done;
    logic [15:0]             crc_out;

    // Payload source view.
    modport master (
        output start,
        output data_in,
        input  tx_bit,
        input  tx_valid,
        input  busy,
        input  done,
        input  crc_out
    );

    // Transmitter view.
    modport slave (
        input  start,
        input  data_in,
        output tx_bit,
        output tx_valid,
        output busy,
        output done,
        output crc_out
    );
endinterface : crc16_frame_tx_if
`default_nettype wire

// File: rtl/crc16_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : crc16_frame_tx
//  Brief    : Serial frame transmitter. It latches a PAYLOAD_BITS payload and
//             shifts it out MSB-first. CRC-16 (poly 0x8005, init 0xFFFF, no
//             reflection, no final XOR) is computed over the outgoing bits.
//             The 16 CRC bits are then appended MSB-first. All state changes
//             on the falling edge of clk. Every output is taken straight from
//             a register.
//  Revision : 1.0  initial release
// ============================================================================
module crc16_frame_tx #(
    parameter int PAYLOAD_BITS = 24
) (
    input  wire logic           clk,
    input  wire logic           rst,
    crc16_frame_tx_if.slave     bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The counter is sized for the whole frame length plus one spare bit.
    // This keeps the PAYLOAD_BITS-1 and 15 compares free of truncation for
    // any legal payload length.
    localparam int                 c_CNT_W    = $clog2(PAYLOAD_BITS + 16) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_PAY = c_CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CRC = c_CNT_W'(15);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [15:0]        c_CRC_INIT = 16'hFFFF;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CRC_OUT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_t                  state_q,    state_d;
    logic [PAYLOAD_BITS-1:0] shreg_q,    shreg_d;
    logic [15:0]             crc_q,      crc_d;
    logic [c_CNT_W-1:0]      cnt_q,      cnt_d;
    logic                    tx_bit_q,   tx_bit_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q,     busy_d;
    logic                    done_q,     done_d;
    logic [15:0]             crc_out_q,  crc_out_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [15:0]             w_crc_step;
    logic [PAYLOAD_BITS-1:0] w_shreg_shl;
    logic [3:0]              w_crc_idx;

    // One serial CRC-16/0x8005 step, written tap by tap.
    function automatic logic [15:0] f_crc_step(input logic [15:0] crc,
                                               input logic        din);
        logic        fb;
        logic [15:0] nxt;
        fb         = crc[15] ^ din;
        nxt[0]     = fb;
        nxt[1]     = crc[0];
        nxt[2]     = crc[1] ^ fb;
        nxt[14:3]  = crc[13:2];
        nxt[15]    = crc[14] ^ fb;
        return nxt;
    endfunction

    // The bit on the line during PAYLOAD is always shreg_q's MSB.
    // That bit is folded into the CRC here, and the shift exposes the next bit.
    assign w_crc_step  = f_crc_step(crc_q, shreg_q[PAYLOAD_BITS-1]);
    assign w_shreg_shl = shreg_q << 1;

    // During CRC_OUT the CRC register is frozen, because crc_out needs the
    // final value once the frame is done. The CRC bits are picked by index
    // instead of shifting. While cnt_q = j the line shows crc[15-j]; this
    // index names the bit to show on the next cycle.
    assign w_crc_idx   = 4'd14 - cnt_q[3:0];

    // ------------------------------------------------------------------------
    // State and output registers; the reset is sampled on the active edge.
    // ------------------------------------------------------------------------
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            crc_q      <= c_CRC_INIT;
            cnt_q      <= '0;
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crc_out_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crc_out_q  <= crc_out_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Each output's value is computed one cycle early and
    // then registered, so nothing on the bus depends combinationally on
    // start or data_in.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        tx_bit_d   = 1'b0;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        crc_out_d  = crc_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Capture the payload now, so later changes on data_in
                    // cannot reach the frame in flight.
                    state_d    = S_PAYLOAD;
                    shreg_d    = bus.data_in;
                    crc_d      = c_CRC_INIT;
                    cnt_d      = '0;
                    tx_bit_d   = bus.data_in[PAYLOAD_BITS-1];
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end

            S_PAYLOAD: begin
                crc_d      = w_crc_step;
                shreg_d    = w_shreg_shl;
                tx_valid_d = 1'b1;
                busy_d     = 1'b1;
                if (cnt_q == c_LAST_PAY) begin
                    // The last payload bit is on the line. The next bit out
                    // is the MSB of the finished CRC.
                    state_d  = S_CRC_OUT;
                    cnt_d    = '0;
                    tx_bit_d = w_crc_step[15];
                end else begin
                    cnt_d    = cnt_q + c_CNT_ONE;
                    tx_bit_d = w_shreg_shl[PAYLOAD_BITS-1];
                end
            end

            S_CRC_OUT: begin
                busy_d = 1'b1;
                if (cnt_q == c_LAST_CRC) begin
                    // crc[0] is on the line. Drop tx_valid and publish the
                    // result together with the done pulse.
                    state_d   = S_DONE;
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    crc_out_d = crc_q;
                end else begin
                    cnt_d      = cnt_q + c_CNT_ONE;
                    tx_valid_d = 1'b1;
                    tx_bit_d   = crc_q[w_crc_idx];
                end
            end

            S_DONE: begin
                // done is high for this single cycle. start is ignored here,
                // so the earliest next acceptance is one edge after IDLE.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    assign bus.tx_bit   = tx_bit_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.crc_out  = crc_out_q;

endmodule : crc16_frame_tx
`default_nettype wire
